// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix host driver: FSM state encoding, header layout and timeout length.
// The timeout length is only used when the driver is built with MM_TIMEOUT_EN.
package matrix_pkg;

    localparam logic [2:0] ST_LOAD_HDR  = 3'd0;
    localparam logic [2:0] ST_LOAD_DATA = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_READ      = 3'd3;
    localparam logic [2:0] ST_ERR       = 3'd4;

    localparam int HDR_M  = 0;
    localparam int HDR_N  = 1;
    localparam int HDR_P  = 2;
    localparam int A_BASE = 3;

    localparam int unsigned TIMEOUT_CYCLES = 32'd1 << 20;

endpackage

// File: rtl/result_skid_buffer.sv
// Two-entry FIFO carrying result words plus their last flag between the memory read pipe and the sink.
// The writer checks count_o before issuing a read, so the FIFO never sees a push while full.
module result_skid_buffer #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_last_i,
    input  logic          in_valid_i,
    output logic [DW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [1:0]    count_o
);

    logic [DW-1:0] data_q [2];
    logic [1:0]    last_q;
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          push;
    logic          pop;

    assign push        = in_valid_i && (count_q != 2'd2);
    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = data_q[rd_ptr_q];
    assign out_last_o  = last_q[rd_ptr_q];
    assign count_o     = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) data_q[i] <= '0;
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= in_data_i;
                last_q[wr_ptr_q] <= in_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/matrix_host_driver.sv
// Host-side loader/reader for the matrix multiplier memory port: header + A + B in, C streamed out.
// Define MM_TIMEOUT_EN to abort a RUN that never sees mm_result_ready within TIMEOUT_CYCLES.
module matrix_host_driver
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int MAX_LEN     = 100,
    parameter int MAX_LEN_LOG = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  error,
    output logic                  mm_reset,
    output logic [ADDR_WIDTH-1:0] mm_address,
    output logic [DATA_WIDTH-1:0] mm_data_in,
    output logic                  mm_write_enable,
    input  logic [DATA_WIDTH-1:0] mm_data_out,
    input  logic                  mm_result_ready
);

    localparam int PW = 2 * MAX_LEN_LOG;
    localparam int SW = PW + 2;
    localparam logic [SW-1:0] MEM_WORDS = SW'(2 ** ADDR_WIDTH);

    logic [2:0]             state_q, state_d;
    logic [1:0]             hdr_cnt_q, hdr_cnt_d;
    logic [MAX_LEN_LOG-1:0] dim_m_q, dim_m_d, dim_n_q, dim_n_d, dim_p;
    logic                   hdr_bad_q, hdr_bad_d;
    logic [SW-1:0]          data_left_q, data_left_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                   wr_en_q, wr_en_d;
    logic                   s_ready_q, s_ready_d;
    logic                   busy_q, busy_d;
    logic                   error_q, error_d;
    logic [ADDR_WIDTH-1:0]  rb_q, rb_d;
    logic [PW-1:0]          mp_q, mp_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [PW-1:0]          rd_cnt_q, rd_cnt_d;
    logic                   infl_q, infl_last_q;
`ifdef MM_TIMEOUT_EN
    logic [31:0]            timer_q, timer_d;
`endif

    logic                   accept, word_bad, hdr_fail, issue, pop;
    logic [PW-1:0]          mn, np, mp;
    logic [SW-1:0]          rb_full, end_full;
    logic [1:0]             buf_count;
    logic                   buf_last;

    assign accept   = s_valid && s_ready_q;
    assign word_bad = (s_data == '0) || (s_data > DATA_WIDTH'(MAX_LEN));
    assign dim_p    = s_data[MAX_LEN_LOG-1:0];
    assign mn       = PW'(dim_m_q) * PW'(dim_n_q);
    assign np       = PW'(dim_n_q) * PW'(dim_p);
    assign mp       = PW'(dim_m_q) * PW'(dim_p);
    assign rb_full  = SW'(A_BASE) + SW'(mn) + SW'(np);
    assign end_full = rb_full + SW'(mp);
    assign hdr_fail = hdr_bad_q || word_bad || (end_full > MEM_WORDS);

    // A read is issued only if the buffer can still hold it, counting the read already in flight.
    assign pop   = m_valid && m_ready;
    assign issue = (state_q == ST_READ) && (rd_cnt_q != mp_q) &&
                   ((3'(buf_count) + 3'(infl_q)) < (3'd2 + 3'(pop)));

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        dim_m_d     = dim_m_q;
        dim_n_d     = dim_n_q;
        hdr_bad_d   = hdr_bad_q;
        data_left_d = data_left_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        busy_d      = busy_q;
        error_d     = error_q;
        rb_d        = rb_q;
        mp_d        = mp_q;
        rd_addr_d   = rd_addr_q;
        rd_cnt_d    = rd_cnt_q;
`ifdef MM_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        case (state_q)
            ST_LOAD_HDR: begin
                if (accept) begin
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_WIDTH'(hdr_cnt_q);
                    wr_data_d = s_data;
                    case (hdr_cnt_q)
                        2'd0: begin
                            dim_m_d   = s_data[MAX_LEN_LOG-1:0];
                            hdr_bad_d = word_bad;
                            hdr_cnt_d = 2'd1;
                        end
                        2'd1: begin
                            dim_n_d   = s_data[MAX_LEN_LOG-1:0];
                            hdr_bad_d = hdr_bad_q || word_bad;
                            hdr_cnt_d = 2'd2;
                        end
                        default: begin
                            hdr_cnt_d   = 2'd0;
                            rb_d        = rb_full[ADDR_WIDTH-1:0];
                            mp_d        = mp;
                            data_left_d = SW'(mn) + SW'(np);
                            if (hdr_fail) begin
                                state_d = ST_ERR;
                                error_d = 1'b1;
                            end else begin
                                state_d = ST_LOAD_DATA;
                            end
                        end
                    endcase
                end
            end
            ST_LOAD_DATA: begin
                // Linger one cycle after the final write so RUN starts only once memory holds B.
                if (data_left_q == '0) begin
                    state_d = ST_RUN;
`ifdef MM_TIMEOUT_EN
                    timer_d = '0;
`endif
                end else if (accept) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = wr_addr_q + ADDR_WIDTH'(1);
                    wr_data_d   = s_data;
                    data_left_d = data_left_q - SW'(1);
                end
            end
            ST_RUN: begin
                if (mm_result_ready) begin
                    state_d   = ST_READ;
                    rd_addr_d = rb_q;
                    rd_cnt_d  = '0;
                end
`ifdef MM_TIMEOUT_EN
                else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
`endif
            end
            ST_READ: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    rd_cnt_d  = rd_cnt_q + PW'(1);
                end
                if (pop && buf_last) begin
                    state_d = ST_LOAD_HDR;
                    busy_d  = 1'b0;
                end
            end
            default: ;
        endcase
        s_ready_d = (state_d == ST_LOAD_HDR) ||
                    ((state_d == ST_LOAD_DATA) && (data_left_d != '0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD_HDR;
            hdr_cnt_q   <= '0;
            dim_m_q     <= '0;
            dim_n_q     <= '0;
            hdr_bad_q   <= 1'b0;
            data_left_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            rb_q        <= '0;
            mp_q        <= '0;
            rd_addr_q   <= '0;
            rd_cnt_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
`ifdef MM_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            dim_m_q     <= dim_m_d;
            dim_n_q     <= dim_n_d;
            hdr_bad_q   <= hdr_bad_d;
            data_left_q <= data_left_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            rb_q        <= rb_d;
            mp_q        <= mp_d;
            rd_addr_q   <= rd_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            infl_q      <= issue;
            infl_last_q <= issue && (rd_cnt_q == mp_q - PW'(1));
`ifdef MM_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    // Read data arrives the cycle after its address, so the in-flight flag marks when to capture it.
    result_skid_buffer #(.DW(DATA_WIDTH)) u_result_buf (
        .clk_i       (clk),
        .rst_ni      (reset),
        .in_data_i   (mm_data_out),
        .in_last_i   (infl_last_q),
        .in_valid_i  (infl_q),
        .out_data_o  (m_data),
        .out_last_o  (buf_last),
        .out_valid_o (m_valid),
        .out_ready_i (m_ready),
        .count_o     (buf_count)
    );

    assign m_last          = m_valid && buf_last;
    assign s_ready         = s_ready_q;
    assign busy            = busy_q;
    assign error           = error_q;
    assign mm_reset        = (state_q != ST_RUN);
    assign mm_address      = (state_q == ST_READ) ? rd_addr_q : wr_addr_q;
    assign mm_data_in      = wr_data_q;
    assign mm_write_enable = wr_en_q;

endmodule

// File: tb/tb_matrix_host_driver.sv
// Directed bench for matrix_host_driver with a behavioural memory and multiplier model.
// Covers basic load/compute/read, backpressure, bad headers, 1x1, mid-load reset and the RUN wait.
module tb_matrix_host_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        busy;
    logic        error;
    logic        mm_reset;
    logic [11:0] mm_address;
    logic [31:0] mm_data_in;
    logic        mm_write_enable;
    logic [31:0] mm_data_out = '0;
    logic        mm_result_ready = 1'b0;

    int nCompared = 0;
    int nMismatched = 0;

    logic [31:0] mem [0:4095];
    bit          mmEnable = 1'b1;
    int          mmCnt = 0;
    int          wlogA[$];
    logic [31:0] wlogD[$];
    logic [31:0] rxData[$];
    logic        rxLast[$];
    int          stabErr = 0;

    always #5 clk = ~clk;

    matrix_host_driver dut (
        .clk             (clk),
        .reset           (reset),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .busy            (busy),
        .error           (error),
        .mm_reset        (mm_reset),
        .mm_address      (mm_address),
        .mm_data_in      (mm_data_in),
        .mm_write_enable (mm_write_enable),
        .mm_data_out     (mm_data_out),
        .mm_result_ready (mm_result_ready)
    );

    // Memory with one-cycle read latency plus a multiplier that computes C a few cycles into RUN.
    always @(posedge clk) begin
        if (mm_write_enable) begin
            mem[mm_address] <= mm_data_in;
            wlogA.push_back(int'(mm_address));
            wlogD.push_back(mm_data_in);
        end
        mm_data_out <= mem[mm_address];
        if (mm_reset) begin
            mmCnt <= 0;
            mm_result_ready <= 1'b0;
        end else if (mmEnable && !mm_result_ready) begin
            mmCnt <= mmCnt + 1;
            if (mmCnt == 4) begin
                int m, n, p, rb;
                logic [31:0] acc;
                m = int'(mem[0]); n = int'(mem[1]); p = int'(mem[2]);
                rb = 3 + m * n + n * p;
                for (int i = 0; i < m; i++)
                    for (int j = 0; j < p; j++) begin
                        acc = '0;
                        for (int k = 0; k < n; k++)
                            acc = acc + mem[3 + i * n + k] * mem[3 + m * n + k * p + j];
                        mem[rb + i * p + j] <= acc;
                    end
                mm_result_ready <= 1'b1;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, output bit ok);
        int waitCyc = 0;
        s_data = w; s_valid = 1'b1;
        while (!s_ready && waitCyc < 100) begin
            @(negedge clk);
            waitCyc++;
        end
        ok = s_ready;
        if (ok) @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_list(input logic [31:0] words[$], output int accepted);
        bit ok;
        accepted = 0;
        foreach (words[i]) begin
            send_word(words[i], ok);
            if (ok) accepted++;
        end
    endtask

    task automatic collect(input int n, input bit toggle);
        int cyc = 0;
        bit stall = 1'b0;
        logic [31:0] held = '0;
        rxData.delete(); rxLast.delete(); stabErr = 0;
        while (rxData.size() < n && cyc < 2000) begin
            m_ready = toggle ? ~cyc[0] : 1'b1;
            if (stall && (m_valid !== 1'b1 || m_data !== held)) stabErr++;
            if (m_valid && m_ready) begin
                rxData.push_back(m_data);
                rxLast.push_back(m_last);
            end
            stall = m_valid && !m_ready;
            held = m_data;
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        nCompared += 8;
        if (s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_s_ready got %b want 0", s_ready); end
        if (m_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_m_valid got %b want 0", m_valid); end
        if (m_last !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_m_last got %b want 0", m_last); end
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        if (error !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_error got %b want 0", error); end
        if (mm_reset !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_mm_reset got %b want 1", mm_reset); end
        if (mm_write_enable !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_we got %b want 0", mm_write_enable); end
        if (mm_address !== 12'd0) begin nMismatched++; $display("[TB] FAIL reset_addr got %0d want 0", mm_address); end
        reset = 1'b1;
        @(negedge clk);
        nCompared++;
        if (s_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL release_s_ready got %b want 1", s_ready); end
    endtask

    task automatic test_basic(input bit toggle, input string tag);
        logic [31:0] words[$] = '{2, 2, 2, 1, 2, 3, 4, 5, 6, 7, 8};
        logic [31:0] expC[4] = '{19, 22, 43, 50};
        int acc;
        wlogA.delete(); wlogD.delete();
        send_list(words, acc);
        nCompared++;
        if (acc !== 11) begin nMismatched++; $display("[TB] FAIL %s_accepted got %0d want 11", tag, acc); end
        nCompared += 2;
        if (s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s_s_ready_after_load got %b want 0", tag, s_ready); end
        if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s_busy_loading got %b want 1", tag, busy); end
        @(negedge clk);
        nCompared++;
        if (wlogA.size() !== 11) begin nMismatched++; $display("[TB] FAIL %s_write_count got %0d want 11", tag, wlogA.size()); end
        for (int i = 0; i < 11 && i < wlogA.size(); i++) begin
            nCompared++;
            if (wlogA[i] !== i || wlogD[i] !== words[i]) begin
                nMismatched++;
                $display("[TB] FAIL %s_write%0d got addr %0d data %0d want addr %0d data %0d", tag, i, wlogA[i], wlogD[i], i, words[i]);
            end
        end
        collect(4, toggle);
        nCompared += 2;
        if (rxData.size() !== 4) begin nMismatched++; $display("[TB] FAIL %s_result_count got %0d want 4", tag, rxData.size()); end
        if (stabErr !== 0) begin nMismatched++; $display("[TB] FAIL %s_hold_stable got %0d changes want 0", tag, stabErr); end
        for (int i = 0; i < 4 && i < rxData.size(); i++) begin
            nCompared++;
            if (rxData[i] !== expC[i] || rxLast[i] !== (i == 3)) begin
                nMismatched++;
                $display("[TB] FAIL %s_C%0d got %0d last %b want %0d last %b", tag, i, rxData[i], rxLast[i], expC[i], (i == 3));
            end
        end
        @(negedge clk);
        nCompared += 3;
        if (m_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s_no_extra got m_valid %b want 0", tag, m_valid); end
        if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s_busy_done got %b want 0", tag, busy); end
        if (s_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s_s_ready_done got %b want 1", tag, s_ready); end
    endtask

    task automatic test_bad_header(input logic [31:0] m, input logic [31:0] n, input logic [31:0] p, input string tag);
        logic [31:0] words[$];
        int acc, high;
        bit ok;
        words = '{m, n, p};
        do_reset();
        wlogA.delete(); wlogD.delete();
        send_list(words, acc);
        nCompared += 4;
        if (acc !== 3) begin nMismatched++; $display("[TB] FAIL %s_hdr_accepted got %0d want 3", tag, acc); end
        if (error !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s_error got %b want 1", tag, error); end
        if (s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s_s_ready got %b want 0", tag, s_ready); end
        if (mm_reset !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s_mm_reset got %b want 1", tag, mm_reset); end
        send_word(32'd9, ok);
        repeat (10) @(negedge clk);
        high = 0;
        foreach (wlogA[i]) if (wlogA[i] >= 3) high++;
        nCompared += 3;
        if (high !== 0) begin nMismatched++; $display("[TB] FAIL %s_data_writes got %0d want 0", tag, high); end
        if (error !== 1'b1 || mm_reset !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s_sticky got error %b mm_reset %b want 1 1", tag, error, mm_reset); end
        if (ok !== 1'b0) begin nMismatched++; $display("[TB] FAIL %s_extra_accept got %b want 0", tag, ok); end
    endtask

    task automatic test_single();
        logic [31:0] words[$] = '{1, 1, 1, 3, 4};
        int acc;
        do_reset();
        send_list(words, acc);
        collect(1, 1'b0);
        nCompared += 2;
        if (acc !== 5) begin nMismatched++; $display("[TB] FAIL single_accepted got %0d want 5", acc); end
        if (rxData.size() !== 1 || rxData[0] !== 32'd12 || rxLast[0] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL single_C got count %0d data %0d want count 1 data 12 last 1", rxData.size(), (rxData.size() > 0) ? rxData[0] : 32'hx);
        end
        @(negedge clk);
        nCompared++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_done got s_ready %b busy %b want 1 0", s_ready, busy); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] words[$] = '{2, 2, 2, 1, 2};
        int acc;
        do_reset();
        send_list(words, acc);
        reset = 1'b0;
        #1;
        nCompared++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || mm_reset !== 1'b1 ||
            mm_write_enable !== 1'b0 || mm_address !== 12'd0 || m_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_outputs got s_ready %b busy %b error %b mm_reset %b we %b addr %0d want 0 0 0 1 0 0",
                     s_ready, busy, error, mm_reset, mm_write_enable, mm_address);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_basic(1'b0, "after_midreset");
    endtask

    task automatic test_run_wait();
        logic [31:0] words[$] = '{1, 1, 1, 3, 4};
        int acc;
        do_reset();
        mmEnable = 1'b0;
        send_list(words, acc);
`ifdef MM_TIMEOUT_EN
        begin
            int cyc = 0;
            while (!error && cyc < (1 << 20) + 100) begin @(negedge clk); cyc++; end
            nCompared++;
            if (error !== 1'b1 || mm_reset !== 1'b1) begin nMismatched++; $display("[TB] FAIL timeout got error %b mm_reset %b want 1 1", error, mm_reset); end
        end
`else
        repeat (300) @(negedge clk);
        nCompared++;
        if (busy !== 1'b1 || error !== 1'b0 || mm_reset !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL run_wait got busy %b error %b mm_reset %b want 1 0 0", busy, error, mm_reset);
        end
`endif
        mmEnable = 1'b1;
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "backpressure");
        test_bad_header(32'd0, 32'd2, 32'd2, "m_zero");
        test_bad_header(32'd2, 32'd2, 32'd101, "p_big");
        test_bad_header(32'd100, 32'd1, 32'd100, "addr_overflow");
        test_single();
        test_reset_mid();
        test_run_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
